vga_addr_gen: RTL

VGA_ADDR_GEN -- requirements
Module: vga_addr_gen

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_xy_counter.sv | 52 +++++
 rtl/vga_addr_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA address generator.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } vga_state_t;

    localparam int DEF_H_PIX   = 128;
    localparam int DEF_V_PIX   = 96;
    localparam int DEF_NUM_BUF = 2;
    localparam int DEF_ADDR_W  = 15;

endpackage

// File: rtl/vga_xy_counter.sv
// Column/line counters with raster wrap, plus line/frame end decode.
module vga_xy_counter #(
    parameter int H_PIX = 128,
    parameter int V_PIX = 96,
    parameter int XW    = 7,
    parameter int YW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic          valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last,
    output logic          line_end,
    output logic          frame_end
);
    localparam logic [XW-1:0] X_MAX = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_PIX - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_max;
    logic          w_y_max;

    assign w_x_max   = (r_x == X_MAX);
    assign w_y_max   = (r_y == Y_MAX);
    assign last      = w_x_max & w_y_max;
    assign line_end  = valid & w_x_max;
    assign frame_end = line_end & w_y_max;
    assign x         = r_x;
    assign y         = r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (adv) begin
            if (w_x_max) begin
                r_x <= '0;
                r_y <= w_y_max ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_addr_gen.sv
// Frame-buffer address generator: FSM, buffer select and incremental address.
module vga_addr_gen
    import vga_pkg::*;
#(
    parameter int H_PIX   = DEF_H_PIX,
    parameter int V_PIX   = DEF_V_PIX,
    parameter int NUM_BUF = DEF_NUM_BUF,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     refresh,
    input  logic                     flag,
    input  logic                     continuous,
    input  logic                     swap_req,
    output logic [ADDR_W-1:0]        direccion,
    output logic [$clog2(H_PIX)-1:0] x,
    output logic [$clog2(V_PIX)-1:0] y,
    output logic                     buf_sel,
    output logic                     addr_valid,
    output logic                     swap_pending,
    output logic                     line_end,
    output logic                     frame_end
);
    localparam int XW = $clog2(H_PIX);
    localparam int YW = $clog2(V_PIX);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(H_PIX * V_PIX);
    localparam logic DUAL = (NUM_BUF == 2);

    if (!(NUM_BUF == 1 || NUM_BUF == 2) || (NUM_BUF * H_PIX * V_PIX > 2 ** ADDR_W)) begin : g_bad_cfg
        $error("vga_addr_gen: bad NUM_BUF or ADDR_W too narrow for the frame buffers");
    end

    vga_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_buf;
    logic              r_pend;
    logic              r_valid;

    logic w_last;
    logic w_active_flag;
    logic w_adv;
    logic w_frame_start;
    logic w_buf_next;

    assign w_active_flag = (r_state == ACTIVE) & flag & ~refresh;
    // A one-shot frame parks on its last pixel, so the counters must not wrap.
    assign w_adv         = w_active_flag & (~w_last | continuous);
    assign w_frame_start = refresh | (w_active_flag & w_last & continuous);
    assign w_buf_next    = r_buf ^ (DUAL & (r_pend | swap_req));

    vga_xy_counter #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX),
        .XW    (XW),
        .YW    (YW)
    ) u_xy (
        .clk       (clk),
        .rst       (rst),
        .clr       (refresh),
        .adv       (w_adv),
        .valid     (r_valid),
        .x         (x),
        .y         (y),
        .last      (w_last),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_buf   <= 1'b0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (refresh) begin
                r_state <= ACTIVE;
                r_valid <= 1'b1;
            end else if (w_active_flag && w_last && !continuous) begin
                r_state <= DONE;
                r_valid <= 1'b0;
            end

            if (w_frame_start) begin
                r_buf  <= w_buf_next;
                r_addr <= w_buf_next ? FRAME_SZ : '0;
                r_pend <= 1'b0;
            end else begin
                if (w_adv)
                    r_addr <= r_addr + 1'b1;
                if (swap_req && DUAL)
                    r_pend <= 1'b1;
            end
        end
    end

    assign direccion    = r_addr;
    assign buf_sel      = r_buf;
    assign swap_pending = r_pend;
    assign addr_valid   = r_valid;

endmodule
